ramctrl: RTL and testbench
==========================

# ramctrl

Memory controller between the byte-wide RAM/IO bus and the two memory clients of the core: instruction fetch (32-bit reads) and the data controller (1/2/4-byte loads and stores). Splits each request into sequential byte accesses, assembles or sign-extends read data, and returns a one-cycle ready pulse to the requester. Data requests have priority over fetch; one request is in flight at a time.

## Interface
Parameters:
- `IO_ADDR_HI`, `17'h00003`: upper address bits [31:15] identifying the IO region; writes there honour `io_buffer_full_in`.

Ports:
- `clk_in` in 1: clock, rising edge.
- `rst_n_in` in 1: one clock; reset is asynchronous and active-low.
- `rdy_in` in 1: global enable; low freezes all state.
- `fetch_ramctrl_en_in` in 1: fetch request, held until ready.
- `fetch_ramctrl_addr_in` in 32: fetch byte address.
- `ramctrl_fetch_rdy_out` out 1: one-cycle completion pulse to fetch.
- `ramctrl_fetch_data_out` out 32: fetched word, valid with rdy.
- `datactrl_ramctrl_data_en_in` in 1: data request, held until ready.
- `datactrl_ramctrl_data_rw_in` in 1: 1 = write, 0 = read.
- `datactrl_ramctrl_data_sgn_in` in 1: read sign-extend.
- `datactrl_ramctrl_data_width_in` in 3: bytes: 1, 2 or 4.
- `datactrl_ramctrl_data_addr_in` in 32: byte address.
- `datactrl_ramctrl_data_data_in` in 32: write data, little-endian.
- `ramctrl_datactrl_data_rdy_out` out 1: one-cycle completion pulse.
- `ramctrl_datactrl_data_data_out` out 32: read data, valid with rdy.
- `mem_din_in` in 8: RAM read byte.
- `mem_dout_out` out 8: RAM write byte.
- `mem_a_out` out 32: RAM address.
- `mem_wr_out` out 1: 1 = write.
- `io_buffer_full_in` in 1: IO write buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: latched addr, width N, sign, write data, owner (fetch/data), byte index k, assembly buffer.
- IDLE: data en high → latch data request, go READ or WRITE by rw; else fetch en high → latch, N=4, go READ. Both high: data wins; fetch stays pending.
- Width other than 1/2/4 treated as 4.
- READ: drive `mem_a_out` = addr+k, k = 0..N-1; byte k captured into buffer bits [8k+7:8k] one cycle after its address. After last capture → DONE.
- Read result: N=1/2 with sgn=1 → sign-extend bit 7/15; sgn=0 → zero-extend. Fetch never extends.
- WRITE: drive addr+k, byte k of write data, `mem_wr_out`=1, one byte per cycle; after byte N-1 → DONE. If address[31:15]==IO_ADDR_HI and `io_buffer_full_in`=1: `mem_wr_out`=0, k does not advance, retry next cycle.
- DONE: owner's rdy=1 for exactly one cycle with data; `mem_wr_out`=0; no new request sampled; → IDLE. Requester must drop en by the edge ending DONE.
- `rdy_in`=0: no register updates; `mem_wr_out` forced 0; resumes at same k.
- Reset (async, any state): state IDLE, k=0, all outputs 0, in-flight request discarded.

## Timing
- All outputs registered except forced `mem_wr_out`=0 under `rdy_in`=0.
- Request sampled at edge T0 in IDLE; address of byte 0 on `mem_a_out` after T0.
- RAM returns byte for address driven in cycle c during cycle c+1.
- Read of N bytes: addresses after T0..T(N-1), captures at T2..T(N+1), rdy high in cycle after T(N+1); 4-byte read: rdy after 6th edge (T5), N+2 cycles latency.
- Write of N bytes (no stall): bytes after T0..T(N-1), rdy in cycle after T(N); each IO stall cycle adds one.
- Minimum spacing between accepted requests: one DONE cycle.

## Test plan
- Fetch read at 0x0000_0100, RAM bytes 13,05,00,93 → `ramctrl_fetch_data_out`=0x9300_0513, rdy one cycle after T5, `mem_a_out` 0x100..0x103.
- Data read width 1, sgn=1 at byte 0x80 → data 0xFFFF_FF80; same with sgn=0 → 0x0000_0080; width 2 sgn=1 bytes 34,F2 → 0xFFFF_F234.
- Data write width 4, data 0xDEADBEEF at 0x200 → bytes EF,BE,AD,DE at 0x200..0x203 with `mem_wr_out`=1, rdy after T4.
- Fetch and data en raised same cycle → data served first, fetch rdy only after data rdy plus DONE/IDLE; no overlap of rdy pulses.
- Write 1 byte to 0x30000 with `io_buffer_full_in` high 3 cycles → `mem_wr_out` low 3 cycles, then one write of the byte, rdy follows.
- `rst_n_in` low mid 4-byte read → outputs 0 immediately, no rdy; `rdy_in` low 2 cycles mid-write → no byte skipped or duplicated.

Source files
------------

// File: rtl/ramctrl.sv
// rtl/ramctrl.sv - byte-serial RAM/IO bus controller for fetch and data clients
// Data requests win over fetch; one request in flight, finished by a one-cycle DONE pulse.
module ramctrl #(
  parameter logic [16:0] IO_ADDR_HI = 17'h00003
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        fetch_ramctrl_en_in,
  input  logic [31:0] fetch_ramctrl_addr_in,
  output logic        ramctrl_fetch_rdy_out,
  output logic [31:0] ramctrl_fetch_data_out,
  input  logic        datactrl_ramctrl_data_en_in,
  input  logic        datactrl_ramctrl_data_rw_in,
  input  logic        datactrl_ramctrl_data_sgn_in,
  input  logic [2:0]  datactrl_ramctrl_data_width_in,
  input  logic [31:0] datactrl_ramctrl_data_addr_in,
  input  logic [31:0] datactrl_ramctrl_data_data_in,
  output logic        ramctrl_datactrl_data_rdy_out,
  output logic [31:0] ramctrl_datactrl_data_data_out,
  input  logic [7:0]  mem_din_in,
  output logic [7:0]  mem_dout_out,
  output logic [31:0] mem_a_out,
  output logic        mem_wr_out,
  input  logic        io_buffer_full_in
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data controller, 0 = fetch
  logic [31:0] addr_q, addr_d;
  logic [2:0]  n_q, n_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        fetch_rdy_q, fetch_rdy_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic        data_rdy_q, data_rdy_d;
  logic [31:0] data_data_q, data_data_d;

  logic        wr_go, finish_rd;
  logic [31:0] wr_addr, wr_data;
  logic [2:0]  wr_n, wr_k, cap_idx;

  function automatic logic [2:0] width_bytes(input logic [2:0] w);
    case (w)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    n_d          = n_q;
    sgn_d        = sgn_q;
    wdata_d      = wdata_q;
    k_d          = k_q;
    buf_d        = buf_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;
    fetch_rdy_d  = 1'b0;
    fetch_data_d = fetch_data_q;
    data_rdy_d   = 1'b0;
    data_data_d  = data_data_q;
    wr_go        = 1'b0;
    finish_rd    = 1'b0;
    wr_addr      = addr_q;
    wr_data      = wdata_q;
    wr_n         = n_q;
    wr_k         = k_q;
    cap_idx      = k_q - 3'd2;

    case (state_q)
      IDLE: begin
        if (datactrl_ramctrl_data_en_in) begin
          owner_d = 1'b1;
          addr_d  = datactrl_ramctrl_data_addr_in;
          n_d     = width_bytes(datactrl_ramctrl_data_width_in);
          sgn_d   = datactrl_ramctrl_data_sgn_in;
          wdata_d = datactrl_ramctrl_data_data_in;
          buf_d   = '0;
          if (datactrl_ramctrl_data_rw_in) begin
            // First byte goes out on the accepting edge, so feed the write step directly.
            state_d = WRITE;
            wr_go   = 1'b1;
            wr_addr = datactrl_ramctrl_data_addr_in;
            wr_data = datactrl_ramctrl_data_data_in;
            wr_n    = width_bytes(datactrl_ramctrl_data_width_in);
            wr_k    = 3'd0;
          end else begin
            state_d = READ;
            mem_a_d = datactrl_ramctrl_data_addr_in;
            k_d     = 3'd1;
          end
        end else if (fetch_ramctrl_en_in) begin
          owner_d = 1'b0;
          addr_d  = fetch_ramctrl_addr_in;
          n_d     = 3'd4;
          sgn_d   = 1'b0;
          buf_d   = '0;
          state_d = READ;
          mem_a_d = fetch_ramctrl_addr_in;
          k_d     = 3'd1;
        end
      end
      READ: begin
        // k counts edges since acceptance: address k issued, byte k-2 arrives now.
        if (k_q < n_q) mem_a_d = addr_q + {29'd0, k_q};
        if (k_q >= 3'd2) buf_d[{cap_idx[1:0], 3'b000} +: 8] = mem_din_in;
        if (k_q == n_q + 3'd1) finish_rd = 1'b1;
        else k_d = k_q + 3'd1;
      end
      WRITE: wr_go = 1'b1;
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase

    if (wr_go) begin
      if (wr_k == wr_n) begin
        state_d    = DONE;
        data_rdy_d = 1'b1;
      end else if (wr_addr[31:15] == IO_ADDR_HI && io_buffer_full_in) begin
        k_d = wr_k;
      end else begin
        mem_a_d    = wr_addr + {29'd0, wr_k};
        mem_dout_d = wr_data[{wr_k[1:0], 3'b000} +: 8];
        mem_wr_d   = 1'b1;
        k_d        = wr_k + 3'd1;
      end
    end

    if (finish_rd) begin
      state_d = DONE;
      if (owner_q) begin
        data_rdy_d = 1'b1;
        if (n_q == 3'd1)
          data_data_d = {{24{sgn_q & buf_d[7]}}, buf_d[7:0]};
        else if (n_q == 3'd2)
          data_data_d = {{16{sgn_q & buf_d[15]}}, buf_d[15:0]};
        else
          data_data_d = buf_d;
      end else begin
        fetch_rdy_d  = 1'b1;
        fetch_data_d = buf_d;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      n_q          <= '0;
      sgn_q        <= 1'b0;
      wdata_q      <= '0;
      k_q          <= '0;
      buf_q        <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      fetch_rdy_q  <= 1'b0;
      fetch_data_q <= '0;
      data_rdy_q   <= 1'b0;
      data_data_q  <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      n_q          <= n_d;
      sgn_q        <= sgn_d;
      wdata_q      <= wdata_d;
      k_q          <= k_d;
      buf_q        <= buf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      fetch_rdy_q  <= fetch_rdy_d;
      fetch_data_q <= fetch_data_d;
      data_rdy_q   <= data_rdy_d;
      data_data_q  <= data_data_d;
    end
  end

  assign mem_a_out                      = mem_a_q;
  assign mem_dout_out                   = mem_dout_q;
  assign mem_wr_out                     = mem_wr_q & rdy_in;
  assign ramctrl_fetch_rdy_out          = fetch_rdy_q;
  assign ramctrl_fetch_data_out         = fetch_data_q;
  assign ramctrl_datactrl_data_rdy_out  = data_rdy_q;
  assign ramctrl_datactrl_data_data_out = data_data_q;

endmodule

// File: tb/tb_ramctrl.sv
// tb/tb_ramctrl.sv - randomized self-checking bench for ramctrl
// Reference: byte-addressed memory array plus request-level latency and byte-order rules.
module tb_ramctrl;
  localparam logic [16:0] IO_HI = 17'h00006;  // places 0x30000 in the IO region

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in;
  logic        fetch_ramctrl_en_in;
  logic [31:0] fetch_ramctrl_addr_in;
  logic        ramctrl_fetch_rdy_out;
  logic [31:0] ramctrl_fetch_data_out;
  logic        datactrl_ramctrl_data_en_in, datactrl_ramctrl_data_rw_in, datactrl_ramctrl_data_sgn_in;
  logic [2:0]  datactrl_ramctrl_data_width_in;
  logic [31:0] datactrl_ramctrl_data_addr_in, datactrl_ramctrl_data_data_in;
  logic        ramctrl_datactrl_data_rdy_out;
  logic [31:0] ramctrl_datactrl_data_data_out;
  logic [7:0]  mem_din_in, mem_dout_out;
  logic [31:0] mem_a_out;
  logic        mem_wr_out, io_buffer_full_in;

  ramctrl #(.IO_ADDR_HI(IO_HI)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .fetch_ramctrl_en_in(fetch_ramctrl_en_in), .fetch_ramctrl_addr_in(fetch_ramctrl_addr_in),
    .ramctrl_fetch_rdy_out(ramctrl_fetch_rdy_out), .ramctrl_fetch_data_out(ramctrl_fetch_data_out),
    .datactrl_ramctrl_data_en_in(datactrl_ramctrl_data_en_in),
    .datactrl_ramctrl_data_rw_in(datactrl_ramctrl_data_rw_in),
    .datactrl_ramctrl_data_sgn_in(datactrl_ramctrl_data_sgn_in),
    .datactrl_ramctrl_data_width_in(datactrl_ramctrl_data_width_in),
    .datactrl_ramctrl_data_addr_in(datactrl_ramctrl_data_addr_in),
    .datactrl_ramctrl_data_data_in(datactrl_ramctrl_data_data_in),
    .ramctrl_datactrl_data_rdy_out(ramctrl_datactrl_data_rdy_out),
    .ramctrl_datactrl_data_data_out(ramctrl_datactrl_data_data_out),
    .mem_din_in(mem_din_in), .mem_dout_out(mem_dout_out), .mem_a_out(mem_a_out),
    .mem_wr_out(mem_wr_out), .io_buffer_full_in(io_buffer_full_in)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  int n_checks = 0, n_pass = 0, overlap = 0;

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd(a + 32'(i));
    if (n == 1 && sgn && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && sgn && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // External RAM: registered read one cycle after the address, writes logged as they hit the bus.
  always @(posedge clk_in) begin
    mem_din_in <= rd(mem_a_out);
    if (mem_wr_out) begin
      wlog_a.push_back(mem_a_out);
      wlog_d.push_back(mem_dout_out);
    end
  end

  always @(negedge clk_in)
    if (ramctrl_fetch_rdy_out && ramctrl_datactrl_data_rdy_out) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic run_req(input bit is_fetch, input bit rw, input bit sgn, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] wd, input int full_len,
                         input int frz_at, input int frz_len);
    int n, cnt, wrs, lows, stall, exp_lat;
    bit got, seen_wr;
    logic [31:0] exp_v;
    n = is_fetch ? 4 : (w == 3'd1 ? 1 : (w == 3'd2 ? 2 : 4));
    if (is_fetch) rw = 1'b0;
    stall = (rw && a[31:15] == IO_HI) ? full_len : 0;
    exp_lat = rw ? n + 1 + stall + frz_len : n + 2;
    exp_v = exp_read(a, n, sgn && !is_fetch);
    wlog_a.delete(); wlog_d.delete();
    @(negedge clk_in);
    if (is_fetch) begin
      fetch_ramctrl_en_in = 1'b1; fetch_ramctrl_addr_in = a;
    end else begin
      datactrl_ramctrl_data_en_in = 1'b1; datactrl_ramctrl_data_rw_in = rw;
      datactrl_ramctrl_data_sgn_in = sgn; datactrl_ramctrl_data_width_in = w;
      datactrl_ramctrl_data_addr_in = a; datactrl_ramctrl_data_data_in = wd;
    end
    io_buffer_full_in = (full_len > 0);
    cnt = 0; wrs = 0; lows = 0; got = 0; seen_wr = 0;
    while (cnt < 60 && !got) begin
      @(posedge clk_in); cnt++;
      @(negedge clk_in);
      if (full_len > 0 && cnt == full_len) io_buffer_full_in = 1'b0;
      if (frz_len > 0 && cnt == frz_at) rdy_in = 1'b0;
      if (frz_len > 0 && cnt == frz_at + frz_len) rdy_in = 1'b1;
      if (mem_wr_out) begin wrs++; seen_wr = 1; end
      else if (!seen_wr) lows++;
      if (!rw && cnt <= n) check("rd_addr", mem_a_out, a + 32'(cnt - 1));
      got = is_fetch ? ramctrl_fetch_rdy_out : ramctrl_datactrl_data_rdy_out;
    end
    check("latency", 32'(cnt), 32'(exp_lat));
    if (!rw) check(is_fetch ? "fetch_data" : "load_data",
                   is_fetch ? ramctrl_fetch_data_out : ramctrl_datactrl_data_data_out, exp_v);
    fetch_ramctrl_en_in = 1'b0; datactrl_ramctrl_data_en_in = 1'b0; io_buffer_full_in = 1'b0;
    @(posedge clk_in); @(negedge clk_in);
    check("rdy_pulse", 32'(is_fetch ? ramctrl_fetch_rdy_out : ramctrl_datactrl_data_rdy_out), 32'd0);
    if (rw) begin
      check("wr_cycles", 32'(wrs), 32'(n));
      check("wr_count", 32'(wlog_a.size()), 32'(n));
      if (stall > 0) check("io_stall_lows", 32'(lows), 32'(stall));
      for (int i = 0; i < n && i < wlog_a.size(); i++) begin
        check("wr_addr", wlog_a[i], a + 32'(i));
        check("wr_byte", 32'(wlog_d[i]), 32'(wd[8*i +: 8]));
      end
      for (int i = 0; i < n; i++) ram[a + 32'(i)] = wd[8*i +: 8];
    end
  endtask

  initial begin
    int cnt, rdys;
    logic [31:0] ra;
    logic [2:0] rw_w;
    rst_n_in = 1'b0; rdy_in = 1'b1; io_buffer_full_in = 1'b0;
    fetch_ramctrl_en_in = 1'b0; fetch_ramctrl_addr_in = '0;
    datactrl_ramctrl_data_en_in = 1'b0; datactrl_ramctrl_data_rw_in = 1'b0;
    datactrl_ramctrl_data_sgn_in = 1'b0; datactrl_ramctrl_data_width_in = 3'd4;
    datactrl_ramctrl_data_addr_in = '0; datactrl_ramctrl_data_data_in = '0;
    #1;
    check("rst_mem_a", mem_a_out, 32'd0);
    check("rst_mem_wr", 32'(mem_wr_out), 32'd0);
    check("rst_fetch_rdy", 32'(ramctrl_fetch_rdy_out), 32'd0);
    check("rst_data_rdy", 32'(ramctrl_datactrl_data_rdy_out), 32'd0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;

    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h93;
    ram[32'h300] = 8'h80; ram[32'h310] = 8'h34; ram[32'h311] = 8'hF2;
    run_req(1, 0, 0, 3'd4, 32'h100, 0, 0, 0, 0);
    check("fetch_word", ramctrl_fetch_data_out, 32'h9300_0513);
    run_req(0, 0, 1, 3'd1, 32'h300, 0, 0, 0, 0);
    run_req(0, 0, 0, 3'd1, 32'h300, 0, 0, 0, 0);
    run_req(0, 0, 1, 3'd2, 32'h310, 0, 0, 0, 0);
    check("lh_sext", ramctrl_datactrl_data_data_out, 32'hFFFF_F234);
    run_req(0, 1, 0, 3'd4, 32'h200, 32'hDEADBEEF, 0, 0, 0);
    run_req(0, 1, 0, 3'd1, 32'h30000, 32'h0000_005A, 3, 0, 0);
    run_req(0, 1, 0, 3'd4, 32'h400, 32'h1234_5678, 0, 2, 2);

    // Simultaneous requests: data first, fetch accepted after DONE plus one IDLE edge.
    @(negedge clk_in);
    fetch_ramctrl_en_in = 1'b1; fetch_ramctrl_addr_in = 32'h100;
    datactrl_ramctrl_data_en_in = 1'b1; datactrl_ramctrl_data_rw_in = 1'b0;
    datactrl_ramctrl_data_width_in = 3'd4; datactrl_ramctrl_data_addr_in = 32'h310;
    cnt = 0;
    do begin @(posedge clk_in); cnt++; @(negedge clk_in); end
    while (!ramctrl_datactrl_data_rdy_out && cnt < 40);
    check("prio_data_lat", 32'(cnt), 32'd6);
    check("prio_data", ramctrl_datactrl_data_data_out, exp_read(32'h310, 4, 0));
    datactrl_ramctrl_data_en_in = 1'b0;
    cnt = 0;
    do begin @(posedge clk_in); cnt++; @(negedge clk_in); end
    while (!ramctrl_fetch_rdy_out && cnt < 40);
    check("prio_fetch_lat", 32'(cnt), 32'd7);
    check("prio_fetch", ramctrl_fetch_data_out, 32'h9300_0513);
    fetch_ramctrl_en_in = 1'b0;
    @(negedge clk_in);

    // Asynchronous reset in the middle of a 4-byte read.
    datactrl_ramctrl_data_en_in = 1'b1; datactrl_ramctrl_data_addr_in = 32'h500;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); #2 rst_n_in = 1'b0; #1;
    check("mid_rst_mem_a", mem_a_out, 32'd0);
    check("mid_rst_fdata", ramctrl_fetch_data_out, 32'd0);
    check("mid_rst_ddata", ramctrl_datactrl_data_data_out, 32'd0);
    datactrl_ramctrl_data_en_in = 1'b0;
    @(negedge clk_in); rst_n_in = 1'b1;
    rdys = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (ramctrl_datactrl_data_rdy_out || ramctrl_fetch_rdy_out) rdys++;
    end
    check("mid_rst_no_rdy", 32'(rdys), 32'd0);

    for (int t = 0; t < 40; t++) begin
      ra = $urandom & 32'h0000_7FF0;
      case ($urandom_range(0, 4))
        0: rw_w = 3'd1;
        1: rw_w = 3'd2;
        2: rw_w = 3'd4;
        3: rw_w = 3'd3;
        default: rw_w = 3'd0;
      endcase
      case ($urandom_range(0, 3))
        0: run_req(1, 0, 0, 3'd4, ra, 0, 0, 0, 0);
        1: run_req(0, 0, 1'($urandom), rw_w, ra, 0, 0, 0, 0);
        2: run_req(0, 1, 0, rw_w, ra, $urandom, $urandom_range(0, 3), 0, 0);
        default: run_req(0, 1, 0, rw_w, {IO_HI, 15'h0} | ra, $urandom, $urandom_range(0, 3), 0, 0);
      endcase
    end
    check("rdy_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
